sysid_timestamp_regs: RTL
=========================

Name: sysid_timestamp_regs

Overview:
- Parametrised successor to the system-ID slave: Avalon-MM register bank giving the software build identity plus live run-time information.
- Registers: ID, build timestamp, 64-bit free-running uptime with coherent hi/lo read, seconds counter, byte-writable scratch word, clear control.
- Registered read path with readdatavalid.
- Sits on the Nios II data master next to the other peripherals; the BSP polls it for version checks and coarse timing.

Parameters:
- ID_VALUE, 0, 32-bit system ID returned at register 0.
- TIMESTAMP, 1485992024, 32-bit build timestamp returned at register 1.
- CLK_HZ, 50000000, clock frequency; seconds prescaler terminal count is CLK_HZ-1 (legal range 2..2^32-1).
- ADDR_W, 3, word-address width (legal range 3..8).
- SCRATCH_RESET, 0, scratch register reset value.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe; one word per asserted cycle.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  write byte lanes; bit n enables bits [8n+7:8n].
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle, the cycle after each accepted read.

Behaviour:
- Reset: applied synchronously at a rising edge while reset=1.
  - readdata=0, readdatavalid=0.
  - uptime=0, prescaler=0, seconds=0, hi_snap=0, scratch=SCRATCH_RESET.
- Slave timing:
  - No waitrequest; every read and write is accepted in the cycle it is asserted.
  - Read latency is fixed at 1 cycle. Reads may be issued back-to-back, one result per cycle.
  - readdata holds its value between reads.
- Read sampling and collisions:
  - A read returns register contents as they were at the edge where the read is accepted, i.e. before that same edge's counter increment or write.
  - Read and write in the same cycle: both are performed; the read returns the pre-write value.
- Register map (word address):
  - 0 ID: RO, ID_VALUE.
  - 1 TIMESTAMP: RO, TIMESTAMP.
  - 2 UPTIME_LO: RO, uptime[31:0]. The same read loads hi_snap <= uptime[63:32] from the same sample.
  - 3 UPTIME_HI: RO, returns hi_snap, not the live upper word. Software reads LO then HI for a coherent 64-bit value.
  - 4 SECONDS: RO, seconds count.
  - 5 SCRATCH: RW; each lane is written only when its byteenable bit is set.
  - 6 CONTROL: write with writedata[0]=1 clears uptime, prescaler and seconds at that edge. hi_snap and scratch are unaffected. Reads return 0.
  - 7 and any higher address (ADDR_W>3): reads return 0; writes are ignored.
- Counters:
  - uptime increments by 1 on every edge not in reset; wraps 2^64-1 -> 0 silently.
  - prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 it returns to 0 and seconds increments; seconds wraps 2^32-1 -> 0.
  - Clear write in the same cycle as an increment: clear wins, all three counters read 0 at the next edge.
- Read hitting register 2 in the same cycle as a clear: returns the pre-clear value, and hi_snap captures the pre-clear upper word.
- Reset asserted while a read is in flight: readdatavalid is 0 on the following cycle (the response is dropped).
- Write strobes to RO addresses have no effect.

Test Plan:
- ID/timestamp: ID_VALUE=32'h0000_0000, default TIMESTAMP; read addr 0, then addr 1 back-to-back -> readdatavalid on two consecutive cycles, data 0 then 1485992024.
- Scratch lanes: write addr 5 with 32'hAABBCCDD, be=4'b1111; then 32'h11223344, be=4'b0101; read addr 5 -> 32'hAA22CC44. A read issued with a write in the same cycle returns the old value.
- Uptime coherence: force uptime=64'h0000_0001_FFFF_FFFE, read addr 2 then addr 3 -> 32'hFFFFFFFE, then 32'h00000001, even though the live upper word has rolled to 2.
- Seconds: CLK_HZ=10; release reset and wait 25 cycles; read addr 4 -> 2. Write addr 6 with data 1 in the same cycle the prescaler reaches 9 -> subsequent reads of addr 2 and addr 4 restart from 0.
- Unmapped/RO: ADDR_W=4; read addr 7 and addr 12 -> 0. Write 32'hFFFFFFFF to addr 0 -> addr 0 still reads ID_VALUE.
- Reset mid-operation: assert reset in the cycle after a read is accepted -> readdatavalid=0, readdata=0. Afterwards addr 5 reads SCRATCH_RESET and addr 2 reads a small count (<4).

Source files
------------

// File: rtl/sysid_timestamp_regs.sv
// sysid_timestamp_regs
// Avalon-MM register bank that reports the software build identity
// (system ID and build timestamp) together with live run-time information.
// The live information is a 64-bit uptime counter with a coherent hi/lo read,
// a seconds counter and a byte-writable scratch word. A control register
// clears the counters.
//
// Word map:
//   0 ID         RO  ID_VALUE
//   1 TIMESTAMP  RO  TIMESTAMP
//   2 UPTIME_LO  RO  uptime[31:0]; the same read snapshots uptime[63:32]
//   3 UPTIME_HI  RO  snapshot taken by the last UPTIME_LO read
//   4 SECONDS    RO  whole seconds counted by the CLK_HZ prescaler
//   5 SCRATCH    RW  byte-lane writable
//   6 CONTROL    WO  writedata[0]=1 clears uptime, prescaler and seconds
//   7+           reads 0, writes ignored
//
// Reads are accepted every cycle and answered one cycle later through
// readdata/readdatavalid. A read reflects state before any update made at the
// edge that accepts it.
//
// UPTIME_RESET is the value uptime takes on reset. It defaults to 0. A
// nonzero value lets a bench reach the 32-bit carry without simulating for
// billions of cycles. A clear always returns uptime to 0.

module sysid_timestamp_regs #(
  parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'd1485992024,
  parameter logic [31:0] CLK_HZ        = 32'd50000000,
  parameter int unsigned ADDR_W        = 3,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
  parameter logic [63:0] UPTIME_RESET  = 64'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [7:0] ADDR_ID        = 8'd0;
  localparam logic [7:0] ADDR_TIMESTAMP = 8'd1;
  localparam logic [7:0] ADDR_UPTIME_LO = 8'd2;
  localparam logic [7:0] ADDR_UPTIME_HI = 8'd3;
  localparam logic [7:0] ADDR_SECONDS   = 8'd4;
  localparam logic [7:0] ADDR_SCRATCH   = 8'd5;
  localparam logic [7:0] ADDR_CONTROL   = 8'd6;

  // The prescaler wraps after CLK_HZ cycles, so its terminal count is CLK_HZ-1.
  localparam logic [31:0] PRESC_TC = CLK_HZ - 32'd1;

  logic [63:0] uptime_q,        uptime_d;
  logic [31:0] presc_q,         presc_d;
  logic [31:0] seconds_q,       seconds_d;
  logic [31:0] hi_snap_q,       hi_snap_d;
  logic [31:0] scratch_q,       scratch_d;
  logic [31:0] readdata_q,      readdata_d;
  logic        readdatavalid_q, readdatavalid_d;

  logic [7:0]  addr_ext;
  logic        clear_hit;
  logic        sec_tick;
  logic [31:0] read_mux;

  // Widen the word address to 8 bits so decoding is the same for every ADDR_W.
  assign addr_ext = 8'(address);

  // Decode the clear strobe and the one-second tick from the current state.
  always_comb begin
    clear_hit = 1'b0;
    sec_tick  = 1'b0;
    if (write && (addr_ext == ADDR_CONTROL) && writedata[0]) begin
      clear_hit = 1'b1;
    end
    if (presc_q == PRESC_TC) begin
      sec_tick = 1'b1;
    end
  end

  // Select the read value from the registers as they stand before this edge.
  always_comb begin
    read_mux = 32'h0;
    case (addr_ext)
      ADDR_ID:        read_mux = ID_VALUE;
      ADDR_TIMESTAMP: read_mux = TIMESTAMP;
      ADDR_UPTIME_LO: read_mux = uptime_q[31:0];
      ADDR_UPTIME_HI: read_mux = hi_snap_q;
      ADDR_SECONDS:   read_mux = seconds_q;
      ADDR_SCRATCH:   read_mux = scratch_q;
      default:        read_mux = 32'h0;
    endcase
  end

  // Advance uptime, prescaler and seconds; a clear overrides every increment.
  always_comb begin
    uptime_d  = uptime_q + 64'd1;
    presc_d   = presc_q + 32'd1;
    seconds_d = seconds_q;
    if (sec_tick) begin
      presc_d   = 32'h0;
      seconds_d = seconds_q + 32'd1;
    end
    if (clear_hit) begin
      uptime_d  = 64'h0;
      presc_d   = 32'h0;
      seconds_d = 32'h0;
    end
  end

  // Merge enabled byte lanes of a SCRATCH write into the scratch word.
  always_comb begin
    scratch_d = scratch_q;
    if (write && (addr_ext == ADDR_SCRATCH)) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byteenable[lane]) begin
          scratch_d[8*lane +: 8] = writedata[8*lane +: 8];
        end
      end
    end
  end

  // Build the read response. An UPTIME_LO read also latches the upper word
  // from the same sample, which makes a following UPTIME_HI read coherent.
  always_comb begin
    readdata_d      = readdata_q;
    readdatavalid_d = 1'b0;
    hi_snap_d       = hi_snap_q;
    if (read) begin
      readdata_d      = read_mux;
      readdatavalid_d = 1'b1;
      if (addr_ext == ADDR_UPTIME_LO) begin
        hi_snap_d = uptime_q[63:32];
      end
    end
  end

  // State register; a synchronous reset also drops any read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q        <= UPTIME_RESET;
      presc_q         <= 32'h0;
      seconds_q       <= 32'h0;
      hi_snap_q       <= 32'h0;
      scratch_q       <= SCRATCH_RESET;
      readdata_q      <= 32'h0;
      readdatavalid_q <= 1'b0;
    end else begin
      uptime_q        <= uptime_d;
      presc_q         <= presc_d;
      seconds_q       <= seconds_d;
      hi_snap_q       <= hi_snap_d;
      scratch_q       <= scratch_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule
